// File: rtl/stepunit_pkg.sv
// stepunit_pkg: shared types and helpers for the step/run clock-enable generator
package stepunit_pkg;

    typedef logic [15:0] addr_t;
    typedef logic [1:0]  rate_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_WAIT,
        S_HELD,
        S_REL_WAIT
    } stepstate_t;

    // Run-mode divisor for a rate setting; each rate step divides by 8, never below 1
    function automatic int unsigned run_div(input int unsigned base, input rate_t r);
        int unsigned d;
        d = base >> (3 * r);
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/stepunit_sync2.sv
// sync2: parameterised-width two-flop synchronizer with a selectable reset value
module sync2
    import stepunit_pkg::*;
#(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Two-stage capture; reset parks both stages at the input's idle value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/stepunit.sv
// stepunit: debounced single-step / divided run-mode clock enable for the CPU core
module stepunit
    import stepunit_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned RUN_DIV         = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_n,
    input  logic       run_sel,
    input  logic [1:0] rate,
    output logic       ce,
    output logic       pressed,
    output addr_t      cycles
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CW = $clog2(RUN_DIV + 1);
    localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam bit ONE_SAMPLE = (DEBOUNCE_CYCLES == 1);

    logic          btn_s;
    logic          run_s;
    rate_t         rate_s;
    logic          run_q;
    rate_t         rate_q;
    stepstate_t    state;
    stepstate_t    state_nx;
    logic [DW-1:0] dcnt;
    logic [DW-1:0] dcnt_nx;
    logic [CW-1:0] dcount;
    logic [CW-1:0] dcount_eff;
    logic [CW-1:0] div_m1;
    logic          key;
    logic          step_evt;
    logic          chg;
    logic          ce_nx;

    sync2 #(.W(1), .RST_VAL(1'b1))  u_btn  (.clk(clk), .rst(rst), .d(btn_n),   .q(btn_s));
    sync2 #(.W(1), .RST_VAL(1'b0))  u_run  (.clk(clk), .rst(rst), .d(run_sel), .q(run_s));
    sync2 #(.W(2), .RST_VAL(2'b00)) u_rate (.clk(clk), .rst(rst), .d(rate),    .q(rate_s));

    assign key     = ~btn_s;
    assign pressed = (state == S_HELD) || (state == S_REL_WAIT);

    // A mode or rate change restarts the period, treating this cycle as count 0
    assign chg        = (run_s != run_q) || (rate_s != rate_q);
    assign div_m1     = CW'(run_div(RUN_DIV, rate_s) - 1);
    assign dcount_eff = chg ? '0 : dcount;
    assign ce_nx      = run_s ? (dcount_eff == div_m1) : step_evt;

    // Debounce: a key edge is accepted only after DEBOUNCE_CYCLES identical samples
    always_comb begin
        state_nx = state;
        dcnt_nx  = dcnt;
        step_evt = 1'b0;
        case (state)
            S_IDLE: begin
                if (key && ONE_SAMPLE) begin
                    state_nx = S_HELD;
                    step_evt = 1'b1;
                end else if (key) begin
                    state_nx = S_PRESS_WAIT;
                    dcnt_nx  = DW'(1);
                end
            end
            S_PRESS_WAIT: begin
                if (!key) begin
                    state_nx = S_IDLE;
                    dcnt_nx  = '0;
                end else if (dcnt == DLAST) begin
                    state_nx = S_HELD;
                    dcnt_nx  = '0;
                    step_evt = 1'b1;
                end else begin
                    dcnt_nx = dcnt + 1'b1;
                end
            end
            S_HELD: begin
                if (!key && ONE_SAMPLE) begin
                    state_nx = S_IDLE;
                end else if (!key) begin
                    state_nx = S_REL_WAIT;
                    dcnt_nx  = DW'(1);
                end
            end
            S_REL_WAIT: begin
                if (key) begin
                    state_nx = S_HELD;
                    dcnt_nx  = '0;
                end else if (dcnt == DLAST) begin
                    state_nx = S_IDLE;
                    dcnt_nx  = '0;
                end else begin
                    dcnt_nx = dcnt + 1'b1;
                end
            end
            default: begin
                state_nx = S_IDLE;
                dcnt_nx  = '0;
            end
        endcase
    end

    // Debounce state; reset always lands in S_IDLE so a held key re-debounces
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            dcnt  <= '0;
        end else begin
            state <= state_nx;
            dcnt  <= dcnt_nx;
        end
    end

    // Run divider, registered enable and issued-enable counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q  <= 1'b0;
            rate_q <= '0;
            dcount <= '0;
            ce     <= 1'b0;
            cycles <= '0;
        end else begin
            run_q  <= run_s;
            rate_q <= rate_s;
            dcount <= (run_s && dcount_eff != div_m1) ? dcount_eff + 1'b1 : '0;
            ce     <= ce_nx;
            cycles <= cycles + addr_t'(ce);
        end
    end

endmodule

// File: tb/tb_stepunit.sv
// tb_stepunit: directed bench for stepunit with DEBOUNCE_CYCLES=4, RUN_DIV=64
module tb_stepunit;
    import stepunit_pkg::*;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    logic  btn_n = 1'b1;
    logic  run_sel = 1'b0;
    rate_t rate = '0;
    logic  ce;
    logic  pressed;
    addr_t cycles;
    int    cyc = 0;
    int    total = 0;
    int    passed = 0;

    typedef struct {
        logic  run;
        rate_t rate;
        int    pre;
        int    lat;
        int    per;
    } vec_t;

    vec_t vecs[7];

    stepunit #(.DEBOUNCE_CYCLES(4), .RUN_DIV(64)) dut (
        .clk(clk), .rst(rst), .btn_n(btn_n), .run_sel(run_sel), .rate(rate),
        .ce(ce), .pressed(pressed), .cycles(cycles)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Cycle number of the next ce seen within the budget, -1 if none
    task automatic find_ce(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ce) begin
                at = cyc;
                return;
            end
        end
    endtask

    initial begin
        int n, f, g, cnt, bad, rise, fall, low, c0, after_ffff;
        addr_t prev;
        // run, rate, idle cycles before the change, first-ce latency from raw edge, period
        vecs[0] = '{1'b1, 2'd0, 0,  66, 64};
        vecs[1] = '{1'b1, 2'd1, 0,  10, 8};
        vecs[2] = '{1'b1, 2'd2, 0,  3,  1};
        vecs[3] = '{1'b1, 2'd3, 0,  3,  1};
        vecs[4] = '{1'b1, 2'd1, 0,  10, 8};
        vecs[5] = '{1'b1, 2'd0, 3,  66, 64};
        vecs[6] = '{1'b1, 2'd1, 30, 10, 8};

        tick(3);
        check("reset ce", ce, 0);
        check("reset pressed", pressed, 0);
        check("reset cycles", cycles, 0);
        rst = 1'b1;
        tick(3);

        // clean press held for 20 cycles
        n = cyc; btn_n = 1'b0; cnt = 0; f = -1; rise = -1; fall = -1;
        for (int i = 1; i <= 35; i++) begin
            @(negedge clk);
            if (ce) begin cnt++; f = cyc - n; end
            if (pressed && rise < 0) rise = cyc - n;
            if (!pressed && rise >= 0 && fall < 0) fall = cyc - n;
            if (i == 20) btn_n = 1'b1;
        end
        check("press ce count", cnt, 1);
        check("press ce cycle", f, 6);
        check("press rise", rise, 6);
        check("press fall", fall, 26);
        check("press cycles", cycles, 1);

        // bouncing key, settling low at +12
        n = cyc; btn_n = 1'b0; cnt = 0; f = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (ce) begin cnt++; f = cyc - n; end
            btn_n = (i < 12) ? logic'((i / 2) % 2) : 1'b0;
        end
        check("bounce ce count", cnt, 1);
        check("bounce ce cycle", f, 18);

        // 2-cycle release glitch while held
        btn_n = 1'b1; cnt = 0; low = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (ce) cnt++;
            if (!pressed) low++;
            if (i == 2) btn_n = 1'b0;
        end
        check("glitch ce count", cnt, 0);
        check("glitch pressed drops", low, 0);
        btn_n = 1'b1;
        tick(10);
        check("release pressed", pressed, 0);
        check("step cycles", cycles, 2);

        foreach (vecs[k]) begin
            tick(vecs[k].pre);
            n = cyc; run_sel = vecs[k].run; rate = vecs[k].rate;
            tick(2);
            find_ce(200, f);
            check($sformatf("run%0d latency", k), (f < 0) ? -1 : f - n, vecs[k].lat);
            find_ce(200, g);
            check($sformatf("run%0d period", k), (f < 0 || g < 0) ? -1 : g - f, vecs[k].per);
        end

        // key activity in run mode (div 8), starting on a ce cycle
        n = g; btn_n = 1'b0; cnt = 0; bad = 0; rise = -1; fall = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (ce) begin cnt++; if ((cyc - n) % 8 != 0) bad++; end
            if (pressed && rise < 0) rise = cyc - n;
            if (!pressed && rise >= 0 && fall < 0) fall = cyc - n;
            if (i == 20) btn_n = 1'b1;
        end
        check("runkey ce count", cnt, 5);
        check("runkey off-period ce", bad, 0);
        check("runkey rise", rise, 6);
        check("runkey fall", fall, 26);

        // continuous enable and 16-bit counter wrap
        rate = 2'd3;
        tick(5);
        check("div1 ce high", ce, 1);
        c0 = cycles; prev = cycles; after_ffff = -1;
        for (int i = 0; i < 65536; i++) begin
            @(negedge clk);
            if (prev == 16'hFFFF && after_ffff < 0) after_ffff = cycles;
            prev = cycles;
        end
        check("wrap ffff next", after_ffff, 0);
        check("wrap 65536", cycles, c0);

        // asynchronous reset mid-period with the key held
        btn_n = 1'b0;
        tick(10);
        check("pre-reset pressed", pressed, 1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("async ce", ce, 0);
        check("async pressed", pressed, 0);
        check("async cycles", cycles, 0);
        run_sel = 1'b0; rate = '0;
        tick(3);
        n = cyc; rst = 1'b1; cnt = 0; f = -1;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (ce) begin cnt++; f = cyc - n; end
        end
        check("held-at-reset ce count", cnt, 1);
        check("held-at-reset ce cycle", f, 6);
        check("held-at-reset cycles", cycles, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/stepunit.md
# stepunit

Clock-enable generator that sits directly upstream of the CPU core and replaces the raw push-button/FPGA-clock mux as the CPU's pacing source. It debounces the step key and emits exactly one `ce` pulse per physical press in step mode, or a periodic `ce` at a switch-selected rate in run mode. It also counts issued enables for the display path. Everything runs on the single FPGA clock; downstream logic qualifies its state updates with `ce`.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable samples required to accept a key edge (10 ms at 50 MHz); must be ≥ 1.
- `RUN_DIV`, default 50000000: base run-mode period in clocks (1 Hz at 50 MHz); must be ≥ 1.

Ports:
- `clk`  in  1  FPGA clock, the only clock.
- `rst`  in  1  asynchronous, active-low reset.
- `btn_n`  in  1  raw step key, active-low, asynchronous, bouncy.
- `run_sel`  in  1  raw switch; 1 = run mode, 0 = step mode. Asynchronous.
- `rate`  in  2  raw switches selecting the run divisor. Asynchronous.
- `ce`  out  1  CPU clock enable, single-cycle pulse.
- `pressed`  out  1  debounced key level (1 = held).
- `cycles`  out  16  count of `ce` pulses issued.

## Operation
- `btn_n`, `run_sel` and `rate` each pass through a 2-flop synchronizer before any use. `key = ~btn_n_sync`.
- Debounce FSM, type `stepstate_t`, with a counter `dcnt` of width `$clog2(DEBOUNCE_CYCLES+1)`:
  - S_IDLE: if `key`=1, go to S_PRESS_WAIT with `dcnt`=1.
  - S_PRESS_WAIT: if `key`=0, go to S_IDLE with `dcnt`=0. If `key`=1 and `dcnt`=DEBOUNCE_CYCLES−1, go to S_HELD and fire the step event. Otherwise increment `dcnt`.
  - S_HELD: if `key`=0, go to S_REL_WAIT with `dcnt`=1.
  - S_REL_WAIT: if `key`=1, go to S_HELD (no new event). If `key`=0 and `dcnt`=DEBOUNCE_CYCLES−1, go to S_IDLE. Otherwise increment `dcnt`.
  - When DEBOUNCE_CYCLES=1, the event fires on the first pressed sample.
- `pressed`=1 in S_HELD and S_REL_WAIT.
- Step mode (`run_sel_sync`=0): `ce` fires only on the step event. The divider is held at 0.
- Run mode (`run_sel_sync`=1):
  - Divisor `div = max(1, RUN_DIV >> (3*rate_sync))`.
  - `dcount` counts 0..div−1 and wraps. `ce` fires when `dcount`=div−1.
  - Step events are ignored for `ce`. The debounce FSM keeps running, so `pressed` stays valid.
- Any change of `run_sel_sync` or `rate_sync` clears `dcount` to 0 in that cycle. The first run-mode `ce` then comes exactly `div` cycles later.
- `cycles` increments by 1 each cycle `ce`=1 and wraps 0xFFFF→0x0000.

## Timing
- Reset (`rst`=0, asynchronous) values:
  - `ce`=0, `pressed`=0, `cycles`=0.
  - FSM in S_IDLE, `dcnt`=0, `dcount`=0.
  - Synchronizer flops preset to their released/zero state: `btn_n` flops=1, others=0.
- Reset deasserted mid-press or mid-count restarts cleanly from S_IDLE. A key already held at release of reset must still satisfy the full debounce before firing.
- Step latency: `ce` is registered. A clean key press at cycle t reaches `key` at t+2, and `ce` is high for exactly one cycle at t+2+DEBOUNCE_CYCLES.
- Release latency: `pressed` falls DEBOUNCE_CYCLES cycles after `key` drops.
- Run period: exactly `div` clocks between `ce` pulses. With `div`=1, `ce` is held high continuously.
- The mode switch takes effect 2 cycles after the raw edge (synchronizer delay). No `ce` is generated by the switch itself.
- `cycles` updates in the cycle after the `ce` pulse it counts.

## Structure
- The shared package gains:
  - `stepstate_t`: enum of S_IDLE, S_PRESS_WAIT, S_HELD, S_REL_WAIT.
  - `rate_t`: 2-bit.
  - `cycles` reuses the package `addr_t` (16-bit).
- One sub-module, `sync2`: a parameterised-width 2-flop synchronizer with a reset-value parameter. It is instantiated three times.
- The top design instantiates `stepunit` in place of the button clock mux. `cpuunit` gains a `ce` input, and `ledunit` takes `cycles` from here.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, RUN_DIV=64.
- Clean press in step mode: `btn_n` low at cycle 10 and held for 20 cycles → single `ce` at cycle 16; `cycles`=1; `pressed` high from 16 until 4 cycles after `key` falls.
- Bounce: `btn_n` toggles every 2 cycles for 12 cycles, then stays low → no `ce` during the bounce; exactly one `ce` 6 cycles after it settles. A 2-cycle release glitch while held → no second `ce`.
- Run mode:
  - `rate`=0 → `ce` every 64 cycles.
  - `rate`=1 → every 8 cycles.
  - `rate`=2 and `rate`=3 → every cycle (divisor clamps to 1).
  - Changing `rate` mid-count → next `ce` exactly `div` cycles after the change is synchronized.
- Key pressed in run mode → `pressed` follows the key, no extra `ce`, period unchanged.
- `cycles` wrap: run mode with `rate`=3 for 65536 cycles → `cycles` reads 0x0000 again. Asserting `rst` mid-period → all outputs 0 immediately, asynchronously.
